inst_fetch: RTL and testbench

//  Fetch stage directly upstream of the IF/ID register. Owns the PC. Issues one instruction

---
 rtl/inst_fetch.sv | 182 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Fetch stage in front of the IF/ID register. It owns the PC and keeps at
//   most one instruction read in flight on a split addr/data handshake. Branch
//   and exception redirects retarget the PC, and a read that was already
//   accepted when a redirect arrived has its return discarded. A one-entry
//   buffer holds {pc, inst, exception, cause}. IF/ID samples that buffer on
//   every edge where pause[1]==0.
//
//   Optional feature macro: INST_FETCH_ADEF_EN enables the fetch alignment
//   check. A misaligned PC then produces an ADEF exception word instead of a
//   read, and fetching stops until the next redirect.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   pause[5:0]          pause[0] holds IF, pause[1] means IF/ID is not sampling
//   branch_flush/target branch redirect
//   exception_flush/target  exception/ertn redirect (wins over branch)
//   inst_req, inst_addr     read request (address == pc)
//   inst_addr_ok            request accepted this cycle
//   inst_data_ok, inst_rdata  read data return
//   if_pc, if_inst, if_is_exception, if_exception_cause  buffered word to IF/ID
//   if_stall_req            fetch-miss stall request
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef ExceptionCauseWidth
`define ExceptionCauseWidth 6
`endif

module inst_fetch #(
   parameter logic [31:0]                      RESET_PC   = 32'h1C000000,
   parameter logic [`ExceptionCauseWidth-1:0]  ADEF_CAUSE = 6'h08
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [5:0]                       pause,
   input  logic                             branch_flush,
   input  logic [31:0]                      branch_target,
   input  logic                             exception_flush,
   input  logic [31:0]                      exception_target,
   output logic                             inst_req,
   output logic [31:0]                      inst_addr,
   input  logic                             inst_addr_ok,
   input  logic                             inst_data_ok,
   input  logic [31:0]                      inst_rdata,
   output logic [31:0]                      if_pc,
   output logic [31:0]                      if_inst,
   output logic                             if_is_exception,
   output logic [`ExceptionCauseWidth-1:0]  if_exception_cause,
   output logic                             if_stall_req
);

`ifdef INST_FETCH_ADEF_EN
   localparam bit ADEF_EN = 1'b1;
`else
   localparam bit ADEF_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

   state_t       state, state_n;
   logic [31:0]  pc, pc_n;
   logic         buf_valid;
   logic         adef_stop, adef_stop_n;
   logic         load_mem, load_adef;
   logic         redirect;
   logic [31:0]  redirect_pc;
   logic         buf_hold;
   logic         misalign;
   logic         unused_pause;

   assign unused_pause = ^pause[5:2];

   assign redirect    = exception_flush | branch_flush;
   assign redirect_pc = exception_flush ? exception_target : branch_target;
   // Buffered word not yet taken by IF/ID: nothing may be fetched into it.
   assign buf_hold    = buf_valid & pause[1];
   assign misalign    = ADEF_EN && (pc[1:0] != 2'b00);
   assign inst_addr   = pc;

   assign if_stall_req = !buf_valid && (state != S_IDLE) && !redirect;

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      load_mem    = 1'b0;
      load_adef   = 1'b0;
      inst_req    = 1'b0;
      adef_stop_n = redirect ? 1'b0 : adef_stop;
      case (state)
         S_IDLE: begin
            if (redirect) begin
               pc_n    = redirect_pc;
               state_n = S_ADDR;
            end else if (!pause[0] && !buf_hold && !adef_stop) begin
               state_n = S_ADDR;
            end
         end
         S_ADDR: begin
            inst_req = !misalign && !buf_hold;
            if (inst_req && inst_addr_ok) begin
               // Accepted together with a redirect: the return is stale.
               state_n = redirect ? S_DRAIN : S_DATA;
               if (redirect) pc_n = redirect_pc;
            end else if (redirect) begin
               pc_n = redirect_pc;
            end else if (misalign && !buf_hold) begin
               load_adef   = 1'b1;
               adef_stop_n = 1'b1;
               state_n     = S_IDLE;
            end
         end
         S_DATA: begin
            if (inst_data_ok) begin
               if (redirect) begin
                  pc_n    = redirect_pc;
                  state_n = S_ADDR;
               end else begin
                  load_mem = 1'b1;
                  pc_n     = pc + 32'd4;
                  state_n  = pause[0] ? S_IDLE : S_ADDR;
               end
            end else if (redirect) begin
               pc_n    = redirect_pc;
               state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (redirect) pc_n = redirect_pc;
            if (inst_data_ok) state_n = S_ADDR;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         adef_stop <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         adef_stop <= adef_stop_n;
      end
   end

   // Output buffer. A load beats consumption on the same edge, so a word
   // arriving while the previous one is taken stays valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_valid          <= 1'b0;
         if_pc              <= RESET_PC;
         if_inst            <= 32'h0;
         if_is_exception    <= 1'b0;
         if_exception_cause <= '0;
      end else if (redirect) begin
         buf_valid          <= 1'b0;
         if_inst            <= 32'h0;
         if_is_exception    <= 1'b0;
         if_exception_cause <= '0;
      end else if (load_mem) begin
         buf_valid          <= 1'b1;
         if_pc              <= pc;
         if_inst            <= inst_rdata;
         if_is_exception    <= 1'b0;
         if_exception_cause <= '0;
      end else if (load_adef) begin
         buf_valid          <= 1'b1;
         if_pc              <= pc;
         if_inst            <= 32'h0;
         if_is_exception    <= 1'b1;
         if_exception_cause <= ADEF_CAUSE;
      end else if (!pause[1]) begin
         buf_valid          <= 1'b0;
         if_inst            <= 32'h0;
         if_is_exception    <= 1'b0;
         if_exception_cause <= '0;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
`ifndef ExceptionCauseWidth
`define ExceptionCauseWidth 6
`endif

module tb_inst_fetch;
   localparam logic [31:0] RESET_PC = 32'h1C000000;

   logic                             clk;
   logic                             rst;
   logic [5:0]                       pause;
   logic                             branch_flush;
   logic [31:0]                      branch_target;
   logic                             exception_flush;
   logic [31:0]                      exception_target;
   logic                             inst_req;
   logic [31:0]                      inst_addr;
   logic                             inst_addr_ok;
   logic                             inst_data_ok;
   logic [31:0]                      inst_rdata;
   logic [31:0]                      if_pc;
   logic [31:0]                      if_inst;
   logic                             if_is_exception;
   logic [`ExceptionCauseWidth-1:0]  if_exception_cause;
   logic                             if_stall_req;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] acc_addr = 32'h0;

   inst_fetch dut (
      .clk(clk), .rst(rst), .pause(pause),
      .branch_flush(branch_flush), .branch_target(branch_target),
      .exception_flush(exception_flush), .exception_target(exception_target),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .if_pc(if_pc), .if_inst(if_inst), .if_is_exception(if_is_exception),
      .if_exception_cause(if_exception_cause), .if_stall_req(if_stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: a fixed, never-zero function of the address.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E3779B1) | 32'h1;
   endfunction

   // The memory returns the word of the most recently accepted address.
   always @(negedge clk) if (inst_req && inst_addr_ok) acc_addr <= inst_addr;
   assign inst_rdata = mem_f(acc_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle of directed stimulus; returns at the following negedge.
   task automatic drive(input logic aok, input logic dok, input logic [5:0] p,
                        input logic bf, input logic [31:0] bt,
                        input logic ef, input logic [31:0] et);
      @(posedge clk); #1;
      inst_addr_ok = aok; inst_data_ok = dok; pause = p;
      branch_flush = bf; branch_target = bt;
      exception_flush = ef; exception_target = et;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      pause = 6'h0; branch_flush = 1'b0; exception_flush = 1'b0;
      branch_target = 32'h0; exception_target = 32'h0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [31:0] rand_target();
      if ($urandom_range(0, 15) == 0) return 32'hFFFFFFF8;
      return RESET_PC + ($urandom_range(0, 255) << 2);
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      logic        outstanding;
      int          lat;
      int          delivered;

      // Reset state
      do_reset();
      chk("rst_req", 32'(inst_req), 0);
      chk("rst_if_pc", if_pc, RESET_PC);
      chk("rst_if_inst", if_inst, 0);
      chk("rst_exc", 32'(if_is_exception), 0);
      chk("rst_cause", 32'(if_exception_cause), 0);
      chk("rst_stall", 32'(if_stall_req), 0);
      rst = 1'b1;

      // Streaming fetch, one word every two cycles
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 6'h0, 0, 0, 0, 0);
         chk("seq_req", 32'(inst_req), 1);
         chk("seq_addr", inst_addr, RESET_PC + 32'(4 * k));
         if (k == 0) chk("seq_stall", 32'(if_stall_req), 1);
         else begin
            chk("seq_if_pc", if_pc, RESET_PC + 32'(4 * (k - 1)));
            chk("seq_if_inst", if_inst, mem_f(RESET_PC + 32'(4 * (k - 1))));
         end
         drive(0, 1, 6'h0, 0, 0, 0, 0);
         chk("seq_bubble", if_inst, 0);
         chk("seq_req_data", 32'(inst_req), 0);
      end

      // IF/ID not sampling for three cycles with a full buffer
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 6'h02, 0, 0, 0, 0);
         chk("hold_req", 32'(inst_req), 0);
         chk("hold_if_pc", if_pc, RESET_PC + 32'd8);
         chk("hold_if_inst", if_inst, mem_f(RESET_PC + 32'd8));
      end
      drive(1, 0, 6'h0, 0, 0, 0, 0);
      chk("resume_req", 32'(inst_req), 1);
      chk("resume_addr", inst_addr, RESET_PC + 32'd12);
      drive(0, 1, 6'h0, 0, 0, 0, 0);

      // Branch while waiting for data, stale word discarded
      drive(1, 0, 6'h0, 0, 0, 0, 0);
      chk("br_addr_before", inst_addr, RESET_PC + 32'd16);
      chk("br_if_pc_before", if_pc, RESET_PC + 32'd12);
      drive(0, 0, 6'h0, 1, 32'h1C000100, 0, 0);
      chk("br_stall_redirect", 32'(if_stall_req), 0);
      drive(0, 1, 6'h0, 0, 0, 0, 0);
      chk("drain_req", 32'(inst_req), 0);
      chk("drain_stall", 32'(if_stall_req), 1);
      drive(0, 0, 6'h0, 0, 0, 0, 0);
      chk("br_no_stale", if_inst, 0);
      chk("br_new_addr", inst_addr, 32'h1C000100);
      chk("br_new_req", 32'(inst_req), 1);

      // Exception and branch together in ADDR: exception wins
      drive(0, 0, 6'h0, 1, 32'h1C000100, 1, 32'h1C00F000);
      drive(1, 0, 6'h0, 0, 0, 0, 0);
      chk("prio_addr", inst_addr, 32'h1C00F000);
      drive(0, 1, 6'h0, 0, 0, 0, 0);
      drive(0, 0, 6'h0, 0, 0, 0, 0);
      chk("prio_if_pc", if_pc, 32'h1C00F000);
      chk("prio_if_inst", if_inst, mem_f(32'h1C00F000));
      chk("prio_next_addr", inst_addr, 32'h1C00F004);

      // Asynchronous reset in the middle of DATA
      drive(1, 0, 6'h0, 0, 0, 0, 0);
      drive(0, 0, 6'h0, 0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk("arst_req", 32'(inst_req), 0);
      chk("arst_if_pc", if_pc, RESET_PC);
      chk("arst_if_inst", if_inst, 0);
      chk("arst_stall", 32'(if_stall_req), 0);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 1, 6'h0, 0, 0, 0, 0);
      chk("arst_first_req", 32'(inst_req), 1);
      chk("arst_first_addr", inst_addr, RESET_PC);
      drive(0, 0, 6'h0, 0, 0, 0, 0);
      chk("arst_late_data", if_inst, 0);
      chk("arst_addr_hold", inst_addr, RESET_PC);

`ifdef INST_FETCH_ADEF_EN
      // Misaligned branch target raises ADEF instead of a read
      drive(0, 0, 6'h0, 1, 32'h1C000102, 0, 0);
      drive(0, 0, 6'h0, 0, 0, 0, 0);
      chk("adef_req", 32'(inst_req), 0);
      drive(0, 0, 6'h02, 0, 0, 0, 0);
      chk("adef_exc", 32'(if_is_exception), 1);
      chk("adef_cause", 32'(if_exception_cause), 32'h08);
      chk("adef_if_pc", if_pc, 32'h1C000102);
      chk("adef_req_after", 32'(inst_req), 0);
`endif

      // Randomized traffic against a transaction-level model: every word
      // IF/ID takes must be the next one in program order since the last
      // redirect, and carry the memory contents of its PC.
      do_reset();
      rst = 1'b1;
      exp_pc = RESET_PC;
      outstanding = 1'b0;
      lat = 0;
      delivered = 0;
      for (int c = 0; c < 3000; c++) begin
         int r;
         @(posedge clk); #1;
         pause = {4'b0, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2)};
         r = $urandom_range(0, 99);
         exception_flush  = (r < 4);
         branch_flush     = (r >= 2 && r < 10);
         exception_target = rand_target();
         branch_target    = rand_target();
         inst_addr_ok = !outstanding && ($urandom_range(0, 3) != 0);
         inst_data_ok = outstanding && (lat == 0) && ($urandom_range(0, 3) != 0);
         if (outstanding && lat > 0) lat--;
         @(negedge clk);
         if (inst_req) chk("rnd_req_gate", 32'(pause[1] && if_inst != 0), 0);
         chk("rnd_stall_full", 32'(if_stall_req && if_inst != 0), 0);
         if (exception_flush || branch_flush) chk("rnd_stall_redirect", 32'(if_stall_req), 0);
         if (!pause[1] && if_inst != 0) begin
            chk("rnd_deliv_pc", if_pc, exp_pc);
            chk("rnd_deliv_inst", if_inst, mem_f(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         if (exception_flush) exp_pc = exception_target;
         else if (branch_flush) exp_pc = branch_target;
         if (inst_data_ok) outstanding = 1'b0;
         if (inst_req && inst_addr_ok) begin
            outstanding = 1'b1;
            lat = $urandom_range(0, 2);
         end
      end
      chk("rnd_progress", 32'(delivered >= 200), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
